// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the LEGv8 pipelined core.
// Holds the program counter, presents a 10-bit word address to the
// instruction ROM, and captures the returned instruction together with
// its PC into the IF/ID pipeline register. Supports stall (hold
// everything), redirect (load branch target and flush IF/ID) and keeps
// a count of real instructions handed to decode.
module fetch_stage #(
  parameter int              N         = 64,
  parameter int              IW        = 32,
  parameter logic [IW-1:0]   NOP_INSTR = 32'h8b1f03ff
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_stall,
  input  logic          i_redirect,
  input  logic [N-1:0]  i_redirect_pc,
  output logic [9:0]    o_imem_addr,
  input  logic [IW-1:0] i_imem_q,
  output logic [N-1:0]  o_pc,
  output logic [N-1:0]  o_if_id_pc,
  output logic [IW-1:0] o_if_id_instr,
  output logic          o_if_id_valid,
  output logic [31:0]   o_fetch_count
);

  // Architectural state of the stage.
  logic [N-1:0]  r_pc;
  logic [N-1:0]  r_if_id_pc;
  logic [IW-1:0] r_if_id_instr;
  logic          r_if_id_valid;
  logic [31:0]   r_fetch_count;

  // Branch target forced onto a word boundary; the low two byte-offset
  // bits of the target are deliberately discarded.
  logic [N-1:0]  w_redirect_target;
  logic          w_unused_target_bits;

  // Sequential PC for the free-running case, wraps modulo 2^N.
  logic [N-1:0]  w_pc_plus4;

  assign w_redirect_target    = {i_redirect_pc[N-1:2], 2'b00};
  assign w_unused_target_bits = ^i_redirect_pc[1:0];
  assign w_pc_plus4           = r_pc + N'(4);

  // The ROM address comes straight from the PC register so that stall
  // and redirect never reach the memory combinationally.
  assign o_imem_addr = r_pc[11:2];

  // PC register: reset > redirect > stall > advance.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc <= '0;
    end else if (i_redirect) begin
      r_pc <= w_redirect_target;
    end else if (!i_stall) begin
      r_pc <= w_pc_plus4;
    end
  end

  // IF/ID register: bubble on reset or redirect, hold on stall,
  // otherwise capture the instruction the ROM returns for the current PC.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_redirect) begin
      r_if_id_instr <= NOP_INSTR;
      r_if_id_pc    <= '0;
      r_if_id_valid <= 1'b0;
    end else if (!i_stall) begin
      r_if_id_instr <= i_imem_q;
      r_if_id_pc    <= r_pc;
      r_if_id_valid <= 1'b1;
    end
  end

  // Debug counter of real instructions handed to decode; only the
  // advance case loads a valid instruction, so only it counts.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_count <= '0;
    end else if (!i_redirect && !i_stall) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign o_pc          = r_pc;
  assign o_if_id_pc    = r_if_id_pc;
  assign o_if_id_instr = r_if_id_instr;
  assign o_if_id_valid = r_if_id_valid;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed testbench for fetch_stage with a reference
// model of the fetch rules and a per-cycle compare process.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h8b1f03ff;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirectPc;
  logic [9:0]  imemAddr;
  logic [31:0] imemQ;
  logic [63:0] pc;
  logic [63:0] ifIdPc;
  logic [31:0] ifIdInstr;
  logic        ifIdValid;
  logic [31:0] fetchCount;

  logic [31:0] rom [0:1023];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [63:0] mPc;
  logic [63:0] mIfPc;
  logic [31:0] mInstr;
  logic        mValid;
  logic [31:0] mCount;
  bit          modelOn = 0;

  fetch_stage dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirectPc),
    .o_imem_addr   (imemAddr),
    .i_imem_q      (imemQ),
    .o_pc          (pc),
    .o_if_id_pc    (ifIdPc),
    .o_if_id_instr (ifIdInstr),
    .o_if_id_valid (ifIdValid),
    .o_fetch_count (fetchCount)
  );

  // Instruction ROM answers combinationally.
  assign imemQ = rom[imemAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report it if it differs.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, return on the
  // following falling edge with outputs settled.
  task automatic applyStimulus(input logic r, input logic s, input logic d, input logic [63:0] t);
    reset      = r;
    stall      = s;
    redirect   = d;
    redirectPc = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Literal check of the IF/ID contents, pc and counter.
  task automatic checkIfId(input string tag, input logic [63:0] expPc, input logic [31:0] expInstr,
                           input logic [63:0] expIfPc, input logic expValid, input logic [31:0] expCount);
    checkOutput({tag, "_pc"}, pc, expPc);
    checkOutput({tag, "_instr"}, {32'd0, ifIdInstr}, {32'd0, expInstr});
    checkOutput({tag, "_ifpc"}, ifIdPc, expIfPc);
    checkOutput({tag, "_valid"}, {63'd0, ifIdValid}, {63'd0, expValid});
    checkOutput({tag, "_count"}, {32'd0, fetchCount}, {32'd0, expCount});
  endtask

  // Model of the stage: what each edge must do to the visible state,
  // including the instruction it must fetch from the ROM.
  always @(posedge clk) begin
    if (reset) begin
      mPc     = 64'd0;
      mIfPc   = 64'd0;
      mInstr  = NOP;
      mValid  = 1'b0;
      mCount  = 32'd0;
      modelOn = 1;
    end else if (redirect) begin
      mPc    = redirectPc & ~64'd3;
      mIfPc  = 64'd0;
      mInstr = NOP;
      mValid = 1'b0;
    end else if (!stall) begin
      mInstr = rom[(mPc / 4) % 1024];
      mIfPc  = mPc;
      mValid = 1'b1;
      mCount = mCount + 32'd1;
      mPc    = mPc + 64'd4;
    end
  end

  // Every cycle after the first reset, all outputs must match the model.
  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("cyc_pc", pc, mPc);
      checkOutput("cyc_addr", {54'd0, imemAddr}, (mPc / 4) % 1024);
      checkOutput("cyc_ifpc", ifIdPc, mIfPc);
      checkOutput("cyc_instr", {32'd0, ifIdInstr}, {32'd0, mInstr});
      checkOutput("cyc_valid", {63'd0, ifIdValid}, {63'd0, mValid});
      checkOutput("cyc_count", {32'd0, fetchCount}, {32'd0, mCount});
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] abcd [4];
  logic [2:0]  mixVec [12];

  initial begin
    abcd[0] = 32'hAAAA0001;
    abcd[1] = 32'hBBBB0002;
    abcd[2] = 32'hCCCC0003;
    abcd[3] = 32'hDDDD0004;
    for (int i = 0; i < 1024; i++) rom[i] = 32'hC0DE0000 | i;
    for (int i = 0; i < 4; i++) rom[i] = abcd[i];

    // {stall, redirect, target-select} mixes for the closing sequence
    mixVec[0]  = 3'b000; mixVec[1]  = 3'b100; mixVec[2]  = 3'b000;
    mixVec[3]  = 3'b011; mixVec[4]  = 3'b100; mixVec[5]  = 3'b100;
    mixVec[6]  = 3'b000; mixVec[7]  = 3'b111; mixVec[8]  = 3'b000;
    mixVec[9]  = 3'b010; mixVec[10] = 3'b010; mixVec[11] = 3'b000;

    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = 64'd0;

    // Reset state
    applyStimulus(1, 0, 0, 64'd0);
    checkIfId("rst", 64'd0, NOP, 64'd0, 1'b0, 32'd0);
    checkOutput("rst_addr", {54'd0, imemAddr}, 64'd0);

    // Four free-running fetches: A@0, B@4, C@8, D@12
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 64'd0);
      checkIfId("run", 64'(4 * (i + 1)), abcd[i], 64'(4 * i), 1'b1, 32'(i + 1));
      checkOutput("run_addr", {54'd0, imemAddr}, 64'(i + 1));
    end

    // Stall three cycles while IF/ID holds B@4
    applyStimulus(1, 0, 0, 64'd0);
    applyStimulus(0, 0, 0, 64'd0);
    applyStimulus(0, 0, 0, 64'd0);
    checkIfId("prestall", 64'd8, abcd[1], 64'd4, 1'b1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 64'd0);
      checkIfId("stall", 64'd8, abcd[1], 64'd4, 1'b1, 32'd2);
    end
    applyStimulus(0, 0, 0, 64'd0);
    checkIfId("unstall", 64'd12, abcd[2], 64'd8, 1'b1, 32'd3);
    applyStimulus(0, 0, 0, 64'd0);
    checkIfId("pre_redir", 64'h10, abcd[3], 64'd12, 1'b1, 32'd4);

    // Redirect to 0xE5 at pc=0x10: target rounded down, bubble, then ROM[57]
    applyStimulus(0, 0, 1, 64'h0E5);
    checkIfId("redir", 64'hE4, NOP, 64'd0, 1'b0, 32'd4);
    applyStimulus(0, 0, 0, 64'd0);
    checkIfId("redir_tgt", 64'hE8, 32'hC0DE0039, 64'hE4, 1'b1, 32'd5);

    // Redirect together with stall behaves as redirect alone
    applyStimulus(0, 1, 1, 64'h203);
    checkIfId("redir_stall", 64'h200, NOP, 64'd0, 1'b0, 32'd5);
    applyStimulus(0, 0, 0, 64'd0);
    checkIfId("redir_stall_tgt", 64'h204, 32'hC0DE0080, 64'h200, 1'b1, 32'd6);

    // Mid-run reset at pc=0x40, fetch_count=16
    applyStimulus(1, 0, 0, 64'd0);
    repeat (16) applyStimulus(0, 0, 0, 64'd0);
    checkIfId("pre_rst", 64'h40, 32'hC0DE000F, 64'h3C, 1'b1, 32'd16);
    applyStimulus(1, 1, 1, 64'h500);
    checkIfId("mid_rst", 64'd0, NOP, 64'd0, 1'b0, 32'd0);
    applyStimulus(0, 0, 0, 64'd0);
    checkIfId("post_rst", 64'd4, abcd[0], 64'd0, 1'b1, 32'd1);

    // Run to the top of the 4 KiB window and wrap the word address
    applyStimulus(1, 0, 0, 64'd0);
    repeat (1023) applyStimulus(0, 0, 0, 64'd0);
    checkOutput("wrap_pc_ffc", pc, 64'hFFC);
    checkOutput("wrap_addr_1023", {54'd0, imemAddr}, 64'd1023);
    applyStimulus(0, 0, 0, 64'd0);
    checkIfId("wrap_last", 64'h1000, 32'hC0DE03FF, 64'hFFC, 1'b1, 32'd1024);
    checkOutput("wrap_addr_0", {54'd0, imemAddr}, 64'd0);
    applyStimulus(0, 0, 0, 64'd0);
    checkIfId("wrap_first", 64'h1004, abcd[0], 64'h1000, 1'b1, 32'd1025);

    // Mixed stall/redirect sequence, checked cycle by cycle against the model
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, mixVec[i][2], mixVec[i][1],
                    mixVec[i][0] ? 64'h0000_0000_0000_0FFA : 64'h0000_0001_0000_0031);
    end
    applyStimulus(0, 0, 0, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
